// File: rtl/txd_arb_pkg.sv
// Shared types and constants for the UART transmit arbiter (txd_arbiter).
package txd_arb_pkg;

  localparam int TXD_BYTE_W      = 8;
  localparam int TXD_ARB_NUM_REQ = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SEND  = 2'd1,
    ST_GUARD = 2'd2,
    ST_DONE  = 2'd3
  } txd_arb_state_e;

endpackage

// File: rtl/txd_arbiter_rr_picker.sv
// Round-robin find-first-set: searches upward from ptr_i+1 with wrap-around.
module rr_picker
  import txd_arb_pkg::*;
#(
  parameter int N  = TXD_ARB_NUM_REQ,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic          valid_o
);

  logic [PW:0]   sum;
  logic [PW-1:0] idx;
  logic          found;

  // ptr_i < N, so ptr_i + k < 2N and a single subtraction wraps it.
  always_comb begin
    gnt_o = '0;
    found = 1'b0;
    sum   = '0;
    idx   = '0;
    for (int k = 1; k <= N; k++) begin
      sum = {1'b0, ptr_i} + (PW+1)'(k);
      if (sum >= (PW+1)'(N)) sum = sum - (PW+1)'(N);
      idx = sum[PW-1:0];
      if (!found && req_i[idx]) begin
        gnt_o[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

  assign valid_o = |req_i;

endmodule

// File: rtl/txd_arbiter.sv
// Packet-locked round-robin arbiter feeding one UART transmitter.
// Optional idle-owner timeout is built when TXD_ARB_TIMEOUT_EN is defined.
module txd_arbiter
  import txd_arb_pkg::*;
#(
  parameter int NUM_REQ        = TXD_ARB_NUM_REQ,
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic                          Clock,
  input  logic                          Reset_n,
  input  logic [NUM_REQ-1:0]            ReqValid,
  input  logic [TXD_BYTE_W*NUM_REQ-1:0] ReqData,
  input  logic [NUM_REQ-1:0]            ReqLast,
  output logic [NUM_REQ-1:0]            ReqAck,
  output logic [NUM_REQ-1:0]            Grant,
  output logic                          TxStart,
  output logic [TXD_BYTE_W-1:0]         TxData,
  input  logic                          TxBusy,
  output logic [1:0]                    DbgState
);

  localparam int PW = $clog2(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 1) begin : g_bad_param
    $error("txd_arbiter: NUM_REQ must be 2..8 and TIMEOUT_CYCLES >= 1");
  end

  txd_arb_state_e          state_q, state_d;
  logic [NUM_REQ-1:0]      grant_q, grant_d;
  logic [NUM_REQ-1:0]      ack_q, ack_d;
  logic [PW-1:0]           ptr_q, ptr_d;
  logic                    last_q, last_d;
  logic                    start_q, start_d;
  logic [TXD_BYTE_W-1:0]   data_q, data_d;

  logic [PW-1:0]           owner_idx;
  logic [TXD_BYTE_W-1:0]   owner_byte;
  logic                    owner_valid;
  logic                    owner_last;
  logic [NUM_REQ-1:0]      pick_gnt;
  logic                    pick_valid;

  rr_picker #(.N(NUM_REQ), .PW(PW)) u_picker (
    .req_i   (ReqValid),
    .ptr_i   (ptr_q),
    .gnt_o   (pick_gnt),
    .valid_o (pick_valid)
  );

  always_comb begin
    owner_idx   = '0;
    owner_byte  = '0;
    owner_valid = 1'b0;
    owner_last  = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_q[i]) begin
        owner_idx   = PW'(i);
        owner_byte  = ReqData[i*TXD_BYTE_W +: TXD_BYTE_W];
        owner_valid = ReqValid[i];
        owner_last  = ReqLast[i];
      end
    end
  end

`ifdef TXD_ARB_TIMEOUT_EN
  localparam int CW = ($clog2(TIMEOUT_CYCLES + 1) > 10) ? $clog2(TIMEOUT_CYCLES + 1) : 10;
  logic [CW-1:0] to_cnt_q, to_cnt_d;
  logic          to_expired;

  assign to_expired = (state_q == ST_SEND) && !owner_valid &&
                      (to_cnt_q == CW'(TIMEOUT_CYCLES - 1));
`endif

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    last_d  = last_q;
    data_d  = data_q;
    ack_d   = '0;
    start_d = 1'b0;
`ifdef TXD_ARB_TIMEOUT_EN
    to_cnt_d = '0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (pick_valid) begin
          grant_d = pick_gnt;
          state_d = ST_SEND;
        end
      end
      ST_SEND: begin
`ifdef TXD_ARB_TIMEOUT_EN
        to_cnt_d = to_cnt_q;
`endif
        if (owner_valid && !TxBusy) begin
          start_d = 1'b1;
          data_d  = owner_byte;
          ack_d   = grant_q;
          last_d  = owner_last;
          state_d = ST_GUARD;
`ifdef TXD_ARB_TIMEOUT_EN
          to_cnt_d = '0;
        end else if (to_expired) begin
          // Stalled owner: abandon the partial packet and rotate past it.
          grant_d  = '0;
          ptr_d    = owner_idx;
          state_d  = ST_IDLE;
          to_cnt_d = '0;
        end else if (!owner_valid) begin
          to_cnt_d = to_cnt_q + 1'b1;
`endif
        end
      end
      // The transmitter raises busy a cycle late; skip one sample of it.
      ST_GUARD: state_d = ST_DONE;
      ST_DONE: begin
        if (!TxBusy) begin
          if (last_q) begin
            grant_d = '0;
            ptr_d   = owner_idx;
            state_d = ST_IDLE;
          end else begin
            state_d = ST_SEND;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      ack_q   <= '0;
      ptr_q   <= PW'(NUM_REQ - 1);
      last_q  <= 1'b0;
      start_q <= 1'b0;
      data_q  <= '0;
`ifdef TXD_ARB_TIMEOUT_EN
      to_cnt_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ack_q   <= ack_d;
      ptr_q   <= ptr_d;
      last_q  <= last_d;
      start_q <= start_d;
      data_q  <= data_d;
`ifdef TXD_ARB_TIMEOUT_EN
      to_cnt_q <= to_cnt_d;
`endif
    end
  end

  assign ReqAck   = ack_q;
  assign Grant    = grant_q;
  assign TxStart  = start_q;
  assign TxData   = data_q;
  assign DbgState = state_q;

endmodule

// File: doc/txd_arbiter.md
# txd_arbiter

- Round-robin arbiter that shares one byte-wide UART transmitter (`async_transmitter`) among `NUM_REQ` byte-stream requesters.
- A grant is held for a whole packet, delimited by `ReqLast`, so bytes from different sources never interleave on `SDO`.
- Sits between producers (ADC readout, command responses, status) and the single transmitter.
- Owns the transmitter's `TxD_start`/`TxD_data` inputs and observes its `TxD_busy`.

## Interface
- `NUM_REQ`, default 4: number of requesters, 2..8.
- `TIMEOUT_CYCLES`, default 1023: idle-owner release limit. Used only with `TXD_ARB_TIMEOUT_EN`.

- `Clock`  in  1  system clock.
- `Reset_n`  in  1  asynchronous, active-low reset.
- `ReqValid`  in  NUM_REQ  requester i has a byte on its data slice.
- `ReqData`  in  8*NUM_REQ  byte of requester i in bits [8i+7:8i].
- `ReqLast`  in  NUM_REQ  the offered byte ends requester i's packet.
- `ReqAck`  out  NUM_REQ  one-cycle pulse: byte of requester i accepted.
- `Grant`  out  NUM_REQ  one-hot current owner; all zero when idle.
- `TxStart`  out  1  start pulse to the transmitter.
- `TxData`  out  8  byte to the transmitter.
- `TxBusy`  in  1  transmitter busy.

## Operation
- All outputs are registered.
- Reset values:
  - `Grant`, `ReqAck`, `TxStart` = 0; `TxData` = 8'h00.
  - State = IDLE.
  - Priority pointer = `NUM_REQ`-1, so requester 0 wins first.
- Requester rule: once `ReqValid[i]`=1, hold `ReqData`, `ReqLast` and `ReqValid` stable until `ReqAck[i]` pulses.
- IDLE:
  - If any `ReqValid` is set, pick the first set bit searching upward from pointer+1, with wrap-around.
  - Register `Grant` one-hot for the winner; go to SEND.
- SEND: wait until `ReqValid[owner]`=1 and `TxBusy`=0. Then, at the next edge:
  - `TxStart`=1 and `TxData`=owner byte, for exactly one cycle;
  - `ReqAck[owner]`=1, for exactly one cycle;
  - capture `ReqLast[owner]`; go to GUARD.
- GUARD: exactly one cycle in which `TxBusy` is ignored, covering transmitter busy-assertion latency; go to DONE.
- DONE: wait for `TxBusy`=0.
  - If the captured last flag is 1: clear `Grant`, set pointer = owner, go to IDLE.
  - Otherwise: keep `Grant`, go to SEND.
- Packet lock: while an owner holds the grant, other requesters are never acked, even if the owner drops `ReqValid`.
- Only the owner is ever acked. `ReqAck` and `Grant` are never non-one-hot.
- Simultaneous requests in IDLE are resolved by the pointer only; no fixed priority.
- Reset mid-transfer:
  - Outputs clear asynchronously.
  - The transmitter may still be busy; SEND waits for `TxBusy`=0, so no byte is corrupted after reset.

## Timing
- `ReqValid` sampled in IDLE at edge n gives `Grant` at n+1.
- With `TxBusy`=0, SEND sampling at edge n+1 gives `TxStart`/`ReqAck` at n+2.
- Byte cadence: at least 3 cycles (SEND, GUARD, DONE) plus the transmitter busy time.
- Back-to-back packets from different requesters add 1 IDLE cycle.
- `TxStart` never asserts while `TxBusy`=1 was sampled in the same cycle.

## Configuration
- Macro: `TXD_ARB_TIMEOUT_EN`.
- Defined:
  - A 10+ bit counter counts cycles in SEND with `ReqValid[owner]`=0.
  - When the count reaches `TIMEOUT_CYCLES`: clear `Grant`, set pointer = owner, go to IDLE. The partial packet is abandoned.
  - The counter clears on each ack and on leaving SEND.
- Not defined: no counter. The grant is held indefinitely until a byte with `ReqLast` is sent.

## Structure
- Shared package `txd_arb_pkg`:
  - state enum (IDLE, SEND, GUARD, DONE);
  - `TXD_BYTE_W` = 8;
  - default `NUM_REQ`.
- One sub-module, `rr_picker`: combinational find-first-set starting at pointer+1 with wrap-around; returns a one-hot result and a valid flag.

## Test plan
- Single requester 0 sends 3 bytes 8'hA1, 8'hA2, 8'hA3 (last) → three `TxStart` pulses, each one cycle wide, each after `TxBusy` falls; `Grant` clears after 8'hA3.
- Requesters 1 and 2 request in the same cycle after reset → requester 1 granted first, requester 2 granted when requester 1's last byte completes.
- Requester 0 holds a packet open (no `ReqLast`) while requester 3 waits → no `ReqAck[3]` until requester 0's last byte.
- `TxBusy` held high for 500 cycles in SEND → no `TxStart`; start pulse issued on the cycle after `TxBusy` falls.
- `Reset_n` pulled low during DONE → `Grant`, `TxStart` and `ReqAck` go to 0 immediately; after release, requester 0 wins first.
- With `TXD_ARB_TIMEOUT_EN`, `TIMEOUT_CYCLES`=16, the owner stalls mid-packet → grant released after 16 cycles and the next requester is served.
